commit_trace_fifo: RTL and testbench

//  Consumes the retirement stream (commit/commit_pc/commit_instr/commit_pre_pc) from the WB stage of top_cpu.

---
 rtl/commit_trace_fifo.sv | 99 +++++++++
 tb/tb_commit_trace_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: tags retired instructions with sequence numbers and buffers them for a host; COMMIT_TRACE_PC_CHECK_EN adds a PC-continuity checker
module commit_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 32,
  parameter int CNT_W = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    commit,
  input  logic [63:0]             commit_pc,
  input  logic [31:0]             commit_instr,
  input  logic [63:0]             commit_pre_pc,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [63:0]             trace_pc,
  output logic [31:0]             trace_instr,
  output logic [63:0]             trace_pre_pc,
  output logic [SEQ_W-1:0]        trace_seq,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    overflow,
  output logic [CNT_W-1:0]        retire_cnt,
  output logic [CNT_W-1:0]        drop_cnt
`ifdef COMMIT_TRACE_PC_CHECK_EN
  ,
  output logic                    pc_mismatch,
  output logic [63:0]             mismatch_pc
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  logic [63:0]      memPc    [DEPTH];
  logic [31:0]      memInstr [DEPTH];
  logic [63:0]      memPrePc [DEPTH];
  logic [SEQ_W-1:0] memSeq   [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic [SEQ_W-1:0] seqCnt;
  logic             full, push, pop;
  assign trace_valid  = occupancy != '0;
  assign full         = occupancy == OW'(DEPTH);
  assign pop          = trace_valid && trace_ready;
  assign push         = commit && (!full || pop);
  assign trace_pc     = trace_valid ? memPc[rdPtr]    : '0;
  assign trace_instr  = trace_valid ? memInstr[rdPtr] : '0;
  assign trace_pre_pc = trace_valid ? memPrePc[rdPtr] : '0;
  assign trace_seq    = trace_valid ? memSeq[rdPtr]   : '0;
  // storage write; contents are masked at the head while empty, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      memPc[wrPtr]    <= commit_pc;
      memInstr[wrPtr] <= commit_instr;
      memPrePc[wrPtr] <= commit_pre_pc;
      memSeq[wrPtr]   <= seqCnt;
    end
  end
  // pointers, occupancy and loss-accounting counters
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      occupancy  <= '0;
      seqCnt     <= '0;
      retire_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop) rdPtr <= rdPtr + AW'(1);
      occupancy <= (push && !pop) ? occupancy + OW'(1) : (pop && !push) ? occupancy - OW'(1) : occupancy;
      if (commit) begin
        seqCnt     <= seqCnt + SEQ_W'(1);
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
      if (commit && !push) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
        overflow <= 1'b1;
      end
    end
  end
`ifdef COMMIT_TRACE_PC_CHECK_EN
  logic        havePrev;
  logic [63:0] prevPrePc;
  // compare each commit PC to the previous commit's predicted next PC; latch only the first miss
  always_ff @(posedge clk) begin
    if (rst) begin
      havePrev    <= 1'b0;
      prevPrePc   <= '0;
      pc_mismatch <= 1'b0;
      mismatch_pc <= '0;
    end else if (commit) begin
      havePrev  <= 1'b1;
      prevPrePc <= commit_pre_pc;
      if (havePrev && commit_pc != prevPrePc && !pc_mismatch) begin
        pc_mismatch <= 1'b1;
        mismatch_pc <= commit_pc;
      end
    end
  end
`endif
endmodule

// File: tb/tb_commit_trace_fifo.sv
// tb_commit_trace_fifo: queue-model scoreboard with random and directed stimulus
module tb_commit_trace_fifo;
  localparam int DEPTH = 16;
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] pre;
    logic [31:0] seq;
  } ent_t;
  logic        clk = 1'b0, rst = 1'b1, commit = 1'b0, trace_ready = 1'b0;
  logic [63:0] commit_pc = '0, commit_pre_pc = '0;
  logic [31:0] commit_instr = '0;
  logic        trace_valid, overflow;
  logic [63:0] trace_pc, trace_pre_pc, retire_cnt, drop_cnt;
  logic [31:0] trace_instr, trace_seq;
  logic [4:0]  occupancy;
`ifdef COMMIT_TRACE_PC_CHECK_EN
  logic        pc_mismatch;
  logic [63:0] mismatch_pc;
  bit          mHave, mMm;
  logic [63:0] mPrev, mMmPc;
`endif
  int errors = 0, checks = 0;
  bit armed = 0, mPop, mPush, mOvf;
  ent_t mq[$];
  ent_t head;
  logic [31:0] mSeq;
  logic [63:0] mRet, mDrop;

  commit_trace_fifo #(.DEPTH(DEPTH), .SEQ_W(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .commit(commit), .commit_pc(commit_pc),
    .commit_instr(commit_instr), .commit_pre_pc(commit_pre_pc),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
    .trace_instr(trace_instr), .trace_pre_pc(trace_pre_pc), .trace_seq(trace_seq),
    .occupancy(occupancy), .overflow(overflow), .retire_cnt(retire_cnt),
    .drop_cnt(drop_cnt)
`ifdef COMMIT_TRACE_PC_CHECK_EN
    , .pc_mismatch(pc_mismatch), .mismatch_pc(mismatch_pc)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic c, input logic r, input logic [63:0] pc, input logic [31:0] ins, input logic [63:0] pre);
    commit = c;
    trace_ready = r;
    commit_pc = pc;
    commit_instr = ins;
    commit_pre_pc = pre;
    @(posedge clk);
    #1;
  endtask

  task automatic rstep(input logic c, input logic r);
    step(c, r, {$urandom, $urandom}, $urandom, {$urandom, $urandom});
  endtask

  task automatic doReset();
    rst = 1'b1;
    rstep(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // reference model: a queue of accepted entries plus plain counters
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mSeq = 0; mRet = 0; mDrop = 0; mOvf = 0;
`ifdef COMMIT_TRACE_PC_CHECK_EN
      mHave = 0; mMm = 0; mPrev = 0; mMmPc = 0;
`endif
    end else begin
      mPop = mq.size() != 0 && trace_ready;
      mPush = commit && (mq.size() < DEPTH || mPop);
      if (mPop) void'(mq.pop_front());
      if (mPush) mq.push_back('{commit_pc, commit_instr, commit_pre_pc, mSeq});
      if (commit) begin
        if (!mPush) begin mDrop++; mOvf = 1; end
        mSeq++;
        mRet++;
`ifdef COMMIT_TRACE_PC_CHECK_EN
        if (mHave && commit_pc != mPrev && !mMm) begin mMm = 1; mMmPc = commit_pc; end
        mHave = 1;
        mPrev = commit_pre_pc;
`endif
      end
    end
  end

  // monitor: compares DUT head and status against the model away from the clock edge
  always @(negedge clk) begin
    if (armed) begin
      check("valid", 64'(trace_valid), 64'(mq.size() != 0));
      check("occupancy", 64'(occupancy), 64'(mq.size()));
      check("retire_cnt", retire_cnt, mRet);
      check("drop_cnt", drop_cnt, mDrop);
      check("overflow", 64'(overflow), 64'(mOvf));
`ifdef COMMIT_TRACE_PC_CHECK_EN
      check("pc_mismatch", 64'(pc_mismatch), 64'(mMm));
      check("mismatch_pc", mismatch_pc, mMmPc);
`endif
      if (trace_valid && mq.size() != 0) begin
        head = mq[0];
        check("head_pc", trace_pc, head.pc);
        check("head_instr", 64'(trace_instr), 64'(head.instr));
        check("head_pre_pc", trace_pre_pc, head.pre);
        check("head_seq", 64'(trace_seq), 64'(head.seq));
      end else if (!trace_valid) begin
        check("empty_data", trace_pc | trace_pre_pc | 64'(trace_instr) | 64'(trace_seq), 64'd0);
      end
    end
  end

  initial begin
    doReset();
    armed = 1;
    check("rst_valid", 64'(trace_valid), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_retire", retire_cnt, 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    step(1'b1, 1'b0, 64'h8000_0000, 32'h0000_0013, 64'h8000_0004);
    check("first_valid", 64'(trace_valid), 64'd1);
    check("first_seq", 64'(trace_seq), 64'd0);
    check("first_occ", 64'(occupancy), 64'd1);
    check("first_retire", retire_cnt, 64'd1);
    check("first_pc", trace_pc, 64'h8000_0000);
    doReset();
    for (int i = 0; i < 20; i++) rstep(1'b1, 1'b0);
    check("fill_occ", 64'(occupancy), 64'd16);
    check("fill_drop", drop_cnt, 64'd4);
    check("fill_overflow", 64'(overflow), 64'd1);
    rstep(1'b1, 1'b1);
    check("fullpop_drop", drop_cnt, 64'd4);
    check("fullpop_occ", 64'(occupancy), 64'd16);
    check("fullpop_head", 64'(trace_seq), 64'd1);
    for (int i = 0; i < 15; i++) rstep(1'b0, 1'b1);
    check("tail_seq", 64'(trace_seq), 64'd20);
    rstep(1'b0, 1'b1);
    check("drained_occ", 64'(occupancy), 64'd0);
    rstep(1'b0, 1'b1);
    check("empty_ready_occ", 64'(occupancy), 64'd0);
    doReset();
    for (int i = 0; i < 100; i++) rstep(1'b1, 1'b1);
    check("stream_drop", drop_cnt, 64'd0);
    check("stream_retire", retire_cnt, 64'd100);
    check("stream_last_seq", 64'(trace_seq), 64'd99);
    doReset();
    for (int i = 0; i < 5; i++) rstep(1'b1, 1'b0);
    check("five_occ", 64'(occupancy), 64'd5);
    rst = 1'b1;
    rstep(1'b0, 1'b0);
    rst = 1'b0;
    check("midrst_valid", 64'(trace_valid), 64'd0);
    check("midrst_occ", 64'(occupancy), 64'd0);
    check("midrst_retire", retire_cnt, 64'd0);
    rstep(1'b1, 1'b0);
    check("midrst_seq", 64'(trace_seq), 64'd0);
    for (int i = 0; i < 2000; i++) rstep(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
    for (int i = 0; i < 1500; i++) rstep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
`ifdef COMMIT_TRACE_PC_CHECK_EN
    doReset();
    step(1'b1, 1'b1, 64'h100, 32'h13, 64'h104);
    step(1'b1, 1'b1, 64'h200, 32'h13, 64'h204);
    step(1'b1, 1'b1, 64'h300, 32'h13, 64'h304);
    check("pcchk_flag", 64'(pc_mismatch), 64'd1);
    check("pcchk_pc", mismatch_pc, 64'h200);
`endif
    rstep(1'b0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
